// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and its users.
package regfile_defs;

  localparam int AW            = 5;
  localparam int DW            = 32;
  localparam int N_SRC_DEFAULT = 3;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  // One writeback holding-buffer entry.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr_i,
// wrapping modulo N. Purely combinational so the caller owns the pointer.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic          found;
  logic [PW-1:0] idx;

  // Scan requesters starting at the pointer and grant the first one found.
  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path infers a latch.
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between N_SRC writeback sources.
// Each source has a one-entry buffer; a round-robin scheduler drains the
// buffers into a registered write stage, and busy_mask flags registers that
// still have a write pending so decode can stall on RAW hazards.
module regfile_wb_arbiter
  import regfile_defs::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int AW    = regfile_defs::AW,
  parameter int DW    = regfile_defs::DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_SRC-1:0]    req_valid,
  input  logic [N_SRC*AW-1:0] req_waddr,
  input  logic [N_SRC*DW-1:0] req_wdata,
  output logic [N_SRC-1:0]    req_ready,
  output logic                we,
  output logic [AW-1:0]       waddr,
  output logic [DW-1:0]       wdata,
  output logic [2**AW-1:0]    busy_mask
);

  localparam int PW = $clog2(N_SRC);

  wb_entry_t        buf_q [N_SRC];
  wb_entry_t        buf_d [N_SRC];
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             we_q, we_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [DW-1:0]    wdata_q, wdata_d;

  logic [AW-1:0]    req_addr [N_SRC];
  logic [DW-1:0]    req_data [N_SRC];
  logic [N_SRC-1:0] buf_v, gnt, conflict, fire;

  // Unpack the flat request buses and collect buffer-valid bits.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      req_addr[i] = req_waddr[i*AW +: AW];
      req_data[i] = req_wdata[i*DW +: DW];
      buf_v[i]    = buf_q[i].valid;
    end
  end

  rr_arbiter #(
    .N  (N_SRC),
    .PW (PW)
  ) u_rr (
    .req_i (buf_v),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  // Refuse a request whose register already has a write pending elsewhere, or
  // that a lower-index source claims this cycle: one pending write per register
  // keeps writes to it in order. Register 0 never conflicts.
  always_comb begin
    conflict = '0;
    for (int i = 0; i < N_SRC; i++) begin
      for (int j = 0; j < N_SRC; j++) begin
        if (j != i && buf_q[j].valid && !gnt[j] && buf_q[j].waddr == req_addr[i])
          conflict[i] = 1'b1;
        if (j < i && req_valid[j] && req_addr[j] == req_addr[i])
          conflict[i] = 1'b1;
      end
      if (req_addr[i] == REG_ZERO)
        conflict[i] = 1'b0;
    end
  end

  assign req_ready = (~buf_v | gnt) & ~conflict;
  assign fire      = req_valid & req_ready;

  // Next state: retire the granted buffer into the write stage, then load any
  // accepted request; a same-cycle refill of the granted buffer wins.
  always_comb begin
    buf_d    = buf_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (gnt[i]) begin
        buf_d[i].valid = 1'b0;
        we_d           = 1'b1;
        waddr_d        = buf_q[i].waddr;
        wdata_d        = buf_q[i].wdata;
        rr_ptr_d       = (i == N_SRC - 1) ? '0 : PW'(i + 1);
      end
      if (fire[i] && req_addr[i] != REG_ZERO)
        buf_d[i] = '{valid: 1'b1, waddr: req_addr[i], wdata: req_data[i]};
    end
  end

  // State registers; reset drops every buffered and in-flight write at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the small buffer array is reset whole, payload included, so the
      // write stage and busy_mask never see stale or X data after reset.
      for (int i = 0; i < N_SRC; i++) buf_q[i] <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      buf_q    <= buf_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Scoreboard of registers with a write buffered or on the port.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (buf_q[i].valid) busy_mask[buf_q[i].waddr] = 1'b1;
    end
    if (we_q) busy_mask[waddr_q] = 1'b1;
    busy_mask[0] = 1'b0;
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random stimulus for regfile_wb_arbiter against a behavioural
// model of the writeback buffers, scheduler and register file.
module tb_regfile_wb_arbiter;
  import regfile_defs::*;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*AW-1:0]  req_waddr;
  logic [N*DW-1:0]  req_wdata;
  logic [N-1:0]     req_ready;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic [2**AW-1:0] busy_mask;

  regfile_wb_arbiter #(.N_SRC(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy_mask (busy_mask)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  bit            m_bv [N];
  logic [AW-1:0] m_ba [N];
  logic [DW-1:0] m_bd [N];
  int            m_ptr;
  bit            m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  logic [N-1:0]  m_fire;
  logic [DW-1:0] m_rf [32];
  logic [DW-1:0] d_rf [32];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_bv[i] = 0; m_ba[i] = '0; m_bd[i] = '0;
    end
    m_ptr = 0; m_we = 0; m_wa = '0; m_wd = '0;
  endtask

  task automatic set_req(int i, bit v, logic [AW-1:0] a, logic [DW-1:0] d);
    req_valid[i]          = v;
    req_waddr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 0, '0, '0);
  endtask

  // One clock: compare outputs to the model before the edge, advance the model,
  // then return just after the edge so the caller can drive new inputs.
  task automatic tick();
    int            g;
    bit            c;
    logic [N-1:0]  rdy;
    logic [31:0]   busy;
    logic [AW-1:0] ai;
    #1;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && m_bv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    busy = '0;
    for (int i = 0; i < N; i++) if (m_bv[i]) busy[m_ba[i]] = 1'b1;
    if (m_we) busy[m_wa] = 1'b1;
    busy[0] = 1'b0;
    for (int i = 0; i < N; i++) begin
      ai = req_waddr[i*AW +: AW];
      c  = 0;
      for (int j = 0; j < N; j++) begin
        if (j != i && m_bv[j] && j != g && m_ba[j] == ai) c = 1;
        if (j < i && req_valid[j] && req_waddr[j*AW +: AW] == ai) c = 1;
      end
      if (ai == '0) c = 0;
      rdy[i] = (!m_bv[i] || i == g) && !c;
    end
    check("ready", req_ready, rdy);
    check("we", we, m_we);
    check("waddr", waddr, m_wa);
    check("wdata", wdata, m_wd);
    check("busy_mask", busy_mask, busy);
    if (we === 1'b1) d_rf[waddr] = wdata;
    if (m_we) m_rf[m_wa] = m_wd;
    m_fire = req_valid & rdy;
    if (g >= 0) begin
      m_we = 1; m_wa = m_ba[g]; m_wd = m_bd[g];
      m_ptr = (g + 1) % N; m_bv[g] = 0;
    end else begin
      m_we = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_fire[i] && req_waddr[i*AW +: AW] != '0) begin
        m_bv[i] = 1;
        m_ba[i] = req_waddr[i*AW +: AW];
        m_bd[i] = req_wdata[i*DW +: DW];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   prev;
    int   nwr;
    int   cnt [4];
    bit   fired;
    logic [DW-1:0] d1, d2;

    for (int r = 0; r < 32; r++) begin m_rf[r] = '0; d_rf[r] = '0; end
    rst_n = 1'b0;
    clear_reqs();
    model_reset();

    // Reset state.
    #3;
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy_mask, 0);
    check("rst_ready", req_ready, 3'b111);
    #9 rst_n = 1'b1;

    // Single request: src1 -> r5.
    set_req(1, 1, 5'd5, 32'h1234);
    tick();
    clear_reqs();
    check("single_busy5", busy_mask[5], 1);
    check("single_we_early", we, 0);
    tick();
    check("single_we", we, 1);
    check("single_waddr", waddr, 5);
    check("single_wdata", wdata, 32'h1234);
    check("single_busy5_port", busy_mask[5], 1);
    tick();
    check("single_idle_busy", busy_mask, 0);

    // All sources valid every cycle with distinct addresses.
    prev = -1; nwr = 0;
    for (int a = 0; a < 4; a++) cnt[a] = 0;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) set_req(i, 1, AW'(i + 1), $urandom());
      tick();
      if (we === 1'b1) begin
        if (prev >= 0) check("rotate", waddr, (prev % 3) + 1);
        prev = int'(waddr);
        nwr++;
        if (prev >= 1 && prev <= 3) cnt[prev]++;
      end
    end
    check("throughput", nwr, 11);
    for (int a = 1; a <= 3; a++) check("no_starve", cnt[a] >= 3, 1);
    clear_reqs();
    repeat (5) tick();

    // Same register from src0 and src2 in one cycle.
    set_req(0, 1, 5'd7, 32'hAAAA_0007);
    set_req(2, 1, 5'd7, 32'hBBBB_0007);
    #1 check("same_addr_ready", req_ready, 3'b011);
    tick();
    set_req(0, 0, '0, '0);
    fired = 0;
    for (int k = 0; k < 8 && !fired; k++) begin
      tick();
      fired = m_fire[2];
    end
    check("src2_accepted", fired, 1);
    clear_reqs();
    repeat (5) tick();
    check("reg7_order", d_rf[7], 32'hBBBB_0007);

    // Write to register 0 is swallowed.
    set_req(1, 1, 5'd0, 32'hFFFF);
    #1 check("zero_ready", req_ready[1], 1);
    tick();
    clear_reqs();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("zero_we", we, 0);
      check("zero_busy", busy_mask, 0);
    end

    // Asynchronous reset with writes buffered and on the port.
    set_req(0, 1, 5'd10, $urandom());
    set_req(1, 1, 5'd11, $urandom());
    set_req(2, 1, 5'd12, $urandom());
    tick();
    clear_reqs();
    tick();
    check("pre_rst_we", we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", we, 0);
    check("arst_busy", busy_mask, 0);
    check("arst_waddr", waddr, 0);
    check("arst_ready", req_ready, 3'b111);
    model_reset();
    #2 rst_n = 1'b1;
    set_req(0, 1, 5'd13, $urandom());
    set_req(1, 1, 5'd14, $urandom());
    set_req(2, 1, 5'd15, $urandom());
    tick();
    clear_reqs();
    tick();
    check("post_rst_first_we", we, 1);
    check("post_rst_first_src0", waddr, 13);
    repeat (5) tick();

    // Grant and refill of src0 in the same cycle.
    d1 = $urandom();
    d2 = $urandom();
    set_req(0, 1, 5'd20, d1);
    tick();
    set_req(0, 1, 5'd21, d2);
    #1 check("refill_ready", req_ready[0], 1);
    tick();
    clear_reqs();
    check("refill_w1_addr", waddr, 20);
    check("refill_busy21", busy_mask[21], 1);
    tick();
    check("refill_w2_we", we, 1);
    check("refill_w2_addr", waddr, 21);
    check("refill_w2_data", wdata, d2);
    repeat (3) tick();

    // Random traffic over a small address range to provoke conflicts.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom());
      tick();
    end
    clear_reqs();
    repeat (6) tick();
    for (int r = 0; r < 32; r++) check("regfile", d_rf[r], m_rf[r]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
